// File: rtl/burst_arb_pkg.sv
// ============================================================================
// Module   : burst_arb_pkg
// Brief    : Shared types, default sizes and burst-length helper for the
//            burst round-robin arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package burst_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int C_DEFAULT_N_REQ = 4;
    localparam int C_DEFAULT_CNT_W = 3;

    // A zero burst field encodes the maximum length 2^cnt_w.
    function automatic int unsigned burst_len(input int unsigned num, input int unsigned cnt_w);
        return (num == 0) ? (32'd1 << cnt_w) : num;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational rotate-priority encoder; first set request at or
//            above ptr, wrapping modulo N_REQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_picker
    import burst_arb_pkg::*;
#(
    parameter int N_REQ = C_DEFAULT_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int w_pos;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_pos = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_pos = int'(ptr) + i;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            if (req[w_pos]) begin
                valid = 1'b1;
                idx   = IDX_W'(w_pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/burst_rr_arbiter.sv
// ============================================================================
// Module   : burst_rr_arbiter
// Brief    : Round-robin arbiter awarding counter-driven grant bursts of
//            1..2^CNT_W cycles, with a mandatory idle cycle between bursts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module burst_rr_arbiter
    import burst_arb_pkg::*;
#(
    parameter int N_REQ = C_DEFAULT_N_REQ,
    parameter int CNT_W = C_DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [CNT_W-1:0]         num_grants,
    output logic [N_REQ-1:0]         gnt,
    output logic                     last,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t             r_state,  w_state_nxt;
    logic [CNT_W:0]     r_cnt,    w_cnt_nxt;
    logic [IDX_W-1:0]   r_ptr,    w_ptr_nxt;
    logic [IDX_W-1:0]   r_owner,  w_owner_nxt;
    logic [N_REQ-1:0]   r_gnt,    w_gnt_nxt;
    logic               r_last,   w_last_nxt;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [CNT_W:0]     w_len;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_len = (CNT_W + 1)'(burst_len(32'(num_grants), CNT_W));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // r_cnt holds the grant cycles remaining including the one on the outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt             = GRANT;
                    w_cnt_nxt               = w_len;
                    w_owner_nxt             = w_pick_idx;
                    w_ptr_nxt               = (w_pick_idx == IDX_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
                    w_gnt_nxt               = '0;
                    w_gnt_nxt[w_pick_idx]   = 1'b1;
                    w_last_nxt              = (w_len == (CNT_W + 1)'(1));
                end
            end
            GRANT: begin
                if (r_cnt == (CNT_W + 1)'(1)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_last_nxt  = (r_cnt == (CNT_W + 1)'(2));
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_gnt_nxt   = '0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    assign gnt   = r_gnt;
    assign last  = r_last;
    assign owner = r_owner;
    assign busy  = |r_gnt;

endmodule

`default_nettype wire

// File: tb/tb_burst_rr_arbiter.sv
// ============================================================================
// Module   : tb_burst_rr_arbiter
// Brief    : Scenario bench for burst_rr_arbiter with a per-cycle scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_burst_rr_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic       last;
        logic [1:0] owner;
        logic       busy;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic [2:0] num_grants = '0;
    logic [3:0] gnt;
    logic       last;
    logic [1:0] owner;
    logic       busy;

    int   checks = 0;
    int   failures = 0;
    obs_t sb[$];

    burst_rr_arbiter #(.N_REQ(4), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .num_grants (num_grants),
        .gnt        (gnt),
        .last       (last),
        .owner      (owner),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [3:0] g, input logic l, input logic [1:0] o);
        obs_t e;
        e.gnt = g; e.last = l; e.owner = o; e.busy = |g;
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, a;
        reset = 1'b1;
        req   = 4'b1111;
        num_grants = 3'd3;
        sb.push_back(mk(4'b0000, 1'b0, 2'd0));
        @(posedge clk); #1;
        e = sb.pop_front(); a = {gnt, last, owner, busy};
        checks++;
        if (a !== e) begin failures++; $display("FAIL reset_state: got %b want %b", a, e); end
        reset = 1'b0;
        req   = '0;
    endtask

    task automatic test_single();
        obs_t e, a;
        do_reset();
        num_grants = 3'd2;
        for (int s = 0; s < 4; s++) begin
            req = (s < 2) ? 4'b0001 : 4'b0000;
            if (s < 2) sb.push_back(mk(4'b0001, s == 1, 2'd0));
            else       sb.push_back(mk(4'b0000, 1'b0, 2'd0));
            @(posedge clk); #1;
            e = sb.pop_front(); a = {gnt, last, owner, busy};
            checks++;
            if (a !== e) begin failures++; $display("FAIL single step %0d: got %b want %b", s, a, e); end
        end
    endtask

    task automatic test_max_len();
        obs_t e, a;
        do_reset();
        num_grants = 3'd0;
        for (int s = 0; s < 10; s++) begin
            req = (s < 8) ? 4'b0100 : 4'b0000;
            if (s < 8) sb.push_back(mk(4'b0100, s == 7, 2'd2));
            else       sb.push_back(mk(4'b0000, 1'b0, 2'd2));
            @(posedge clk); #1;
            e = sb.pop_front(); a = {gnt, last, owner, busy};
            checks++;
            if (a !== e) begin failures++; $display("FAIL max_len step %0d: got %b want %b", s, a, e); end
        end
    endtask

    task automatic test_round_robin();
        obs_t e, a;
        logic [1:0] w;
        do_reset();
        num_grants = 3'd3;
        for (int b = 0; b < 5; b++) begin
            w = 2'(b % 4);
            for (int k = 0; k < 4; k++) begin
                if (k < 3) begin
                    req = 4'b1111;
                    sb.push_back(mk(4'b0001 << w, k == 2, w));
                end else begin
                    req = 4'b1111 & ~(4'b0001 << w);
                    sb.push_back(mk(4'b0000, 1'b0, w));
                end
                @(posedge clk); #1;
                e = sb.pop_front(); a = {gnt, last, owner, busy};
                checks++;
                if (a !== e) begin failures++; $display("FAIL round_robin burst %0d step %0d: got %b want %b", b, k, a, e); end
            end
        end
        req = '0;
    endtask

    task automatic test_early_drop();
        obs_t e, a;
        do_reset();
        num_grants = 3'd5;
        for (int s = 0; s < 7; s++) begin
            req = (s == 0) ? 4'b0010 : 4'b0000;
            if (s < 5) sb.push_back(mk(4'b0010, s == 4, 2'd1));
            else       sb.push_back(mk(4'b0000, 1'b0, 2'd1));
            @(posedge clk); #1;
            e = sb.pop_front(); a = {gnt, last, owner, busy};
            checks++;
            if (a !== e) begin failures++; $display("FAIL early_drop step %0d: got %b want %b", s, a, e); end
        end
    endtask

    task automatic test_len_change();
        obs_t e, a;
        do_reset();
        for (int s = 0; s < 7; s++) begin
            num_grants = (s == 0) ? 3'd4 : 3'd1;
            req = (s < 4 || s == 5) ? 4'b0001 : 4'b0000;
            if (s < 4)       sb.push_back(mk(4'b0001, s == 3, 2'd0));
            else if (s == 5) sb.push_back(mk(4'b0001, 1'b1, 2'd0));
            else             sb.push_back(mk(4'b0000, 1'b0, 2'd0));
            @(posedge clk); #1;
            e = sb.pop_front(); a = {gnt, last, owner, busy};
            checks++;
            if (a !== e) begin failures++; $display("FAIL len_change step %0d: got %b want %b", s, a, e); end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, a;
        do_reset();
        num_grants = 3'd6;
        for (int s = 0; s < 3; s++) begin
            req = 4'b0001;
            sb.push_back(mk(4'b0001, 1'b0, 2'd0));
            @(posedge clk); #1;
            e = sb.pop_front(); a = {gnt, last, owner, busy};
            checks++;
            if (a !== e) begin failures++; $display("FAIL async_pre step %0d: got %b want %b", s, a, e); end
        end
        #2 reset = 1'b1;
        sb.push_back(mk(4'b0000, 1'b0, 2'd0));
        #1;
        e = sb.pop_front(); a = {gnt, last, owner, busy};
        checks++;
        if (a !== e) begin failures++; $display("FAIL async_now: got %b want %b", a, e); end
        req = '0;
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        // ptr must be back at 0, so requester 0 beats requester 1.
        for (int s = 0; s < 2; s++) begin
            req = (s == 0) ? 4'b0011 : 4'b0010;
            num_grants = 3'd1;
            if (s == 0) sb.push_back(mk(4'b0001, 1'b1, 2'd0));
            else        sb.push_back(mk(4'b0000, 1'b0, 2'd0));
            @(posedge clk); #1;
            e = sb.pop_front(); a = {gnt, last, owner, busy};
            checks++;
            if (a !== e) begin failures++; $display("FAIL async_post step %0d: got %b want %b", s, a, e); end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_len();
        test_round_robin();
        test_early_drop();
        test_len_change();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
